ft600_tx_scheduler: RTL and testbench



---
 rtl/ft600_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_ft600_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_tx_scheduler.sv
// ft600_tx_scheduler: round-robin arbiter sharing the FT600 bridge TX write
// port among four FWFT source FIFOs. Each grant emits a header word
// {2'b10, id, 4'b0000, len} followed by len data words popped from the source.
module ft600_tx_scheduler #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEVEL_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*LEVEL_W-1:0] src_level,
    input  logic [63:0]          src_data,
    output logic [3:0]           src_rd,
    output logic                 tx_en,
    output logic [15:0]          tx_in,
    input  logic                 tx_full,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    localparam int unsigned CMP_W = (LEVEL_W > 32) ? LEVEL_W : 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         gid;
    logic [1:0]         last;
    logic [7:0]         len;
    logic [7:0]         cnt;

    logic [LEVEL_W-1:0] level_a [4];
    logic [15:0]        data_a  [4];
    logic               hit;
    logic [1:0]         pick;
    logic [1:0]         cand;
    logic [7:0]         pick_len;

    // Split the flat source buses into per-source fields
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            level_a[i] = src_level[i*LEVEL_W +: LEVEL_W];
            data_a[i]  = src_data[i*16 +: 16];
        end
    end

    // Rotating priority scan: last+1 first, last itself lowest
    always_comb begin
        hit  = 1'b0;
        pick = last;
        cand = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!hit && level_a[cand] != '0) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    // Burst length of the candidate, clamped to MAX_BURST
    always_comb begin
        if (CMP_W'(level_a[pick]) > CMP_W'(MAX_BURST))
            pick_len = 8'(MAX_BURST);
        else
            pick_len = 8'(level_a[pick]);
    end

    // Write strobes and word mux; gated by tx_full so a stalled word is re-presented
    always_comb begin
        tx_en  = 1'b0;
        src_rd = '0;
        tx_in  = '0;
        case (state)
            HDR: begin
                tx_en = ~tx_full;
                tx_in = {2'b10, gid, 4'b0000, len};
            end
            DATA: begin
                tx_en       = ~tx_full;
                tx_in       = data_a[gid];
                src_rd[gid] = ~tx_full;
            end
            default: ;
        endcase
    end

    // Packet sequencing: arbitrate, send header, stream len words
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gid   <= '0;
            last  <= 2'd3;
            len   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        gid   <= pick;
                        len   <= pick_len;
                        cnt   <= pick_len;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (!tx_full)
                        state <= DATA;
                end
                DATA: begin
                    if (!tx_full) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state <= IDLE;
                            last  <= gid;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_id = gid;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ft600_tx_scheduler.sv
// Self-checking bench for ft600_tx_scheduler: source FIFOs are modelled as
// arrays; expected TX stream is derived packet-by-packet from the arbitration
// rules and compared word-for-word against the bridge write port.
module tb_ft600_tx_scheduler;

    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned LEVEL_W   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [4*LEVEL_W-1:0] src_level;
    logic [63:0]          src_data;
    logic [3:0]           src_rd;
    logic                 tx_en;
    logic [15:0]          tx_in;
    logic                 tx_full = 1'b0;
    logic [1:0]           grant_id;
    logic                 busy;

    ft600_tx_scheduler #(.MAX_BURST(MAX_BURST), .LEVEL_W(LEVEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .src_level(src_level),
        .src_data (src_data),
        .src_rd   (src_rd),
        .tx_en    (tx_en),
        .tx_in    (tx_in),
        .tx_full  (tx_full),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // 100 MHz user clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic [3:0]  rd;
    } exp_t;

    int          ntot = 0;
    int          nbad = 0;
    int          busy_n = 0;
    int          model_last = 3;
    logic [15:0] mem [4][256];
    int unsigned wr_p [4] = '{0, 0, 0, 0};
    int unsigned rd_p [4] = '{0, 0, 0, 0};
    exp_t        exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        ntot++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push(input int s, input logic [15:0] w);
        mem[s][wr_p[s] % 256] = w;
        wr_p[s]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            int unsigned lv;
            lv = wr_p[i] - rd_p[i];
            src_level[i*LEVEL_W +: LEVEL_W] = LEVEL_W'(lv);
            src_data[i*16 +: 16] = (lv != 0) ? mem[i][rd_p[i] % 256] : 16'hDEAD;
        end
    endtask

    // Reference: drain the current FIFO contents packet by packet
    task automatic build_expect();
        int   cnt [4];
        int   p   [4];
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = int'(wr_p[i] - rd_p[i]);
            p[i]   = int'(rd_p[i]);
        end
        while (1) begin
            int pick;
            int n;
            pick = -1;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (model_last + k) % 4;
                if (pick < 0 && cnt[c] > 0) pick = c;
            end
            if (pick < 0) break;
            n = (cnt[pick] > int'(MAX_BURST)) ? int'(MAX_BURST) : cnt[pick];
            e.w  = 16'(32'h8000 + (pick * 4096) + n);
            e.rd = 4'b0000;
            exp_q.push_back(e);
            for (int j = 0; j < n; j++) begin
                e.w  = mem[pick][(p[pick] + j) % 256];
                e.rd = 4'(1 << pick);
                exp_q.push_back(e);
            end
            p[pick]   += n;
            cnt[pick] -= n;
            model_last = pick;
        end
    endtask

    task automatic step(input bit bp);
        exp_t       e;
        logic [3:0] rd_s;
        @(negedge clk);
        drive_inputs();
        tx_full = bp ? ($urandom_range(0, 9) < 3) : 1'b0;
        #1;
        if (busy) busy_n++;
        if (tx_full) check("wr_when_full", {27'd0, tx_en, src_rd}, 32'd0);
        if (tx_en) begin
            if (exp_q.size() == 0) begin
                check("extra_wr", {31'd0, tx_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_in", {16'd0, tx_in}, {16'd0, e.w});
                check("src_rd", {28'd0, src_rd}, {28'd0, e.rd});
            end
        end else if (!tx_full) begin
            check("rd_no_wr", {28'd0, src_rd}, 32'd0);
        end
        rd_s = src_rd;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (rd_s[i] && rd_p[i] != wr_p[i]) rd_p[i]++;
    endtask

    task automatic run_phase(input bit bp, input int budget);
        exp_q.delete();
        build_expect();
        busy_n = 0;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) step(bp);
        if (exp_q.size() != 0) check("timeout", exp_q.size(), 32'd0);
        repeat (4) step(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        tx_full = 1'b0;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        model_last = 3;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] rd_s;

        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_en", {31'd0, tx_en}, 32'd0);
        check("rst_src_rd", {28'd0, src_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_tx_in", {16'd0, tx_in}, 32'd0);
        rst = 1'b0;
        model_last = 3;

        // single packet
        push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333);
        run_phase(1'b0, 50);
        check("busy_cycles", busy_n, 32'd4);

        // rotation from reset
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 16'($urandom));
        run_phase(1'b0, 50);

        // burst cap
        for (int j = 0; j < 40; j++) push(2, 16'($urandom));
        run_phase(1'b0, 200);
        check("cap_pops", rd_p[2], wr_p[2]);

        // backpressure on an 8-word burst
        for (int j = 0; j < 8; j++) push(1, 16'($urandom));
        run_phase(1'b1, 200);

        // fairness between a deep and a shallow source
        do_reset();
        for (int j = 0; j < 40; j++) push(0, 16'($urandom));
        push(3, 16'($urandom)); push(3, 16'($urandom));
        run_phase(1'b1, 400);

        // reset mid-burst
        do_reset();
        for (int j = 0; j < 10; j++) push(0, 16'($urandom));
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            drive_inputs();
            tx_full = 1'b0;
            #1;
            if (tx_en && src_rd != 4'b0000) n++;
            rd_s = src_rd;
            @(posedge clk);
            for (int i = 0; i < 4; i++)
                if (rd_s[i] && rd_p[i] != wr_p[i]) rd_p[i]++;
        end
        check("rstmid_words", n, 32'd4);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_tx_en", {31'd0, tx_en}, 32'd0);
        check("rstmid_src_rd", {28'd0, src_rd}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        rd_p[0] = wr_p[0];
        push(1, 16'($urandom)); push(1, 16'($urandom));
        drive_inputs();
        rst        = 1'b0;
        model_last = 3;
        run_phase(1'b0, 100);

        // randomized mixes with random backpressure
        for (int ph = 0; ph < 8; ph++) begin
            for (int s = 0; s < 4; s++) begin
                int k;
                k = int'($urandom_range(0, 40));
                for (int j = 0; j < k; j++) push(s, 16'($urandom));
            end
            run_phase(1'b1, 2000);
        end

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
